// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single wishbone-simulator memory port between NREQ requesters
// (icache miss fetch, icache refill lanes, data side). Fixed priority with
// index 0 highest, a per-requester starvation counter that promotes a
// requester after STARVE_LIMIT lost arbitrations, one transaction in flight,
// and a response timeout that reports an error and then drains the late
// memory response.
//
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   i_req        in   NREQ     request level per requester, held until gnt
//   i_req_we     in   NREQ     write enable per requester
//   i_req_addr   in   32*NREQ  byte address, requester i at [32i+31:32i]
//   i_req_wdata  in   32*NREQ  write data, same packing as i_req_addr
//   o_gnt        out  NREQ     one-hot pulse: request accepted and latched
//   o_rsp_valid  out  NREQ     one-hot pulse to the owner on completion
//   o_rsp_err    out  1        qualifies o_rsp_valid, 1 = timeout
//   o_rsp_rdata  out  32       read data, valid with o_rsp_valid
//   o_mem_req    out  1        one-cycle request pulse to the memory port
//   o_mem_we     out  1        latched write enable
//   o_mem_addr   out  32       latched address
//   o_mem_wdata  out  32       latched write data
//   i_mem_busy   in   1        memory port busy, blocks arbitration in IDLE
//   i_mem_valid  in   1        memory response pulse
//   i_mem_rdata  in   32       memory read data
//   o_arb_busy   out  1        high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ-1:0]      i_req_we,
    input  logic [32*NREQ-1:0]   i_req_addr,
    input  logic [32*NREQ-1:0]   i_req_wdata,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_rsp_valid,
    output logic                 o_rsp_err,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [31:0]          o_mem_addr,
    output logic [31:0]          o_mem_wdata,
    input  logic                 i_mem_busy,
    input  logic                 i_mem_valid,
    input  logic [31:0]          i_mem_rdata,
    output logic                 o_arb_busy
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    // The counter is cleared in ISSUE and counts from 0 in the first WAIT
    // cycle, so the TIMEOUT-th cycle after mem_req sees TIMEOUT-1.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [OW-1:0]   r_owner;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [SW-1:0]   r_starve [NREQ];
    logic [TW-1:0]   r_tcount;

    logic            w_arb;
    logic            w_found;
    logic [OW-1:0]   w_winner;
    logic            w_sel_we;
    logic [31:0]     w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic            w_timeout;
    logic [NREQ-1:0] w_owner_hot;

    // An arbitration only happens in IDLE, with something requesting and
    // the memory port free. mem_busy freezes the starve counters too.
    assign w_arb = (r_state == IDLE) && (|i_req) && !i_mem_busy;

    // Winner selection: a promoted (starved) requester beats plain priority.
    // The promoted candidate must still be requesting, so a requester that
    // withdrew this cycle cannot be granted on a stale counter value.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i] && (r_starve[i] == STARVE_MAX)) begin
                w_found  = 1'b1;
                w_winner = OW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found  = 1'b1;
                w_winner = OW'(i);
            end
        end
    end

    // Pick the winner's request fields for latching.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == OW'(i)) begin
                w_sel_we    = i_req_we[i];
                w_sel_addr  = i_req_addr[32*i +: 32];
                w_sel_wdata = i_req_wdata[32*i +: 32];
            end
        end
    end

    // One-hot decode of the latched owner for gnt/rsp_valid.
    always_comb begin
        w_owner_hot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_owner_hot[i] = 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == WAIT) && (r_tcount == TIMEOUT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. A mem_valid coinciding with the timeout cycle wins
    // and completes normally.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (i_mem_valid) begin
                    w_next_state = IDLE;
                end else if (w_timeout) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (i_mem_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output logic. Responses pass mem_valid/mem_rdata through in the same
    // cycle; a late response in DRAIN is swallowed.
    always_comb begin
        o_gnt       = '0;
        o_rsp_valid = '0;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = '0;
        o_mem_req   = 1'b0;
        case (r_state)
            ISSUE: begin
                o_gnt     = w_owner_hot;
                o_mem_req = 1'b1;
            end
            WAIT: begin
                if (i_mem_valid) begin
                    o_rsp_valid = w_owner_hot;
                    o_rsp_rdata = i_mem_rdata;
                end else if (w_timeout) begin
                    o_rsp_valid = w_owner_hot;
                    o_rsp_err   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_arb_busy  = (r_state != IDLE);

    // Transaction latch. Captured at arbitration and held until the next
    // one, so later changes on the requester side cannot disturb the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_arb) begin
            r_owner <= w_winner;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    // Starve counters: a dropped request clears its counter in any cycle;
    // during an arbitration the winner clears and requesting losers count
    // up, saturating at the promotion threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_starve[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!i_req[i]) begin
                    r_starve[i] <= '0;
                end else if (w_arb) begin
                    if (w_winner == OW'(i)) begin
                        r_starve[i] <= '0;
                    end else if (r_starve[i] != STARVE_MAX) begin
                        r_starve[i] <= r_starve[i] + SW'(1);
                    end
                end
            end
        end
    end

    // Response timeout counter, restarted every time a request is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcount <= '0;
        end else if (r_state == ISSUE) begin
            r_tcount <= '0;
        end else if (r_state == WAIT) begin
            r_tcount <= r_tcount + TW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios (single read, priority, starvation, timeout, busy/write,
// reset in WAIT) followed by randomized traffic. A transaction-level model
// of the arbiter predicts every output on every falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NREQ         = 3;
    localparam int STARVE_LIMIT = 8;
    localparam int TIMEOUT      = 64;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     i_req;
    logic [NREQ-1:0]     i_req_we;
    logic [32*NREQ-1:0]  i_req_addr;
    logic [32*NREQ-1:0]  i_req_wdata;
    logic [NREQ-1:0]     o_gnt;
    logic [NREQ-1:0]     o_rsp_valid;
    logic                o_rsp_err;
    logic [31:0]         o_rsp_rdata;
    logic                o_mem_req;
    logic                o_mem_we;
    logic [31:0]         o_mem_addr;
    logic [31:0]         o_mem_wdata;
    logic                i_mem_busy;
    logic                i_mem_valid;
    logic [31:0]         i_mem_rdata;
    logic                o_arb_busy;

    mem_port_arbiter #(
        .NREQ         (NREQ),
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_gnt       (o_gnt),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_err   (o_rsp_err),
        .o_rsp_rdata (o_rsp_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_busy  (i_mem_busy),
        .i_mem_valid (i_mem_valid),
        .i_mem_rdata (i_mem_rdata),
        .o_arb_busy  (o_arb_busy)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Memory responder and requester knobs
    int              memLatency  = 2;
    bit              memSilent   = 1'b0;
    bit              memFixed    = 1'b0;
    logic [31:0]     memData     = 32'h0;
    int              memCountdown = 0;
    logic [NREQ-1:0] gntSeen     = '0;
    logic [NREQ-1:0] holdReq     = '0;

    // Transaction-level model state
    bit          mActive   = 1'b0;
    bit          mDraining = 1'b0;
    int          mAge      = 0;
    int          mOwner    = 0;
    logic        mWe       = 1'b0;
    logic [31:0] mAddr     = 32'h0;
    logic [31:0] mWdata    = 32'h0;
    int          mStarve [NREQ];

    // Observation log of the DUT, used by the directed scenarios
    int          gntLog [$];
    int          gntCycle [NREQ];
    logic [31:0] gntAddr [NREQ];
    logic [31:0] gntWdata [NREQ];
    logic        gntWe [NREQ];
    int          rspCycle [NREQ];
    int          rspCount = 0;
    int          rspOwner = -1;
    logic [31:0] rspData  = 32'h0;
    logic        rspErr   = 1'b0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h cycle=%0d",
                     name, actual, expected, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // The memory responder watches for mem_req and requesters watch for gnt
    // away from the clock edge; reactions are applied in tick().
    always @(negedge clk) begin
        if (rst_n && o_mem_req && !memSilent) memCountdown = memLatency;
        gntSeen = o_gnt;
    end

    // Reference model and compare process. The model tracks a transaction
    // by its age in cycles since arbitration: age 1 is the grant cycle, and
    // age-1 is the number of cycles since mem_req.
    always @(negedge clk) begin
        logic [NREQ-1:0] expGnt;
        logic [NREQ-1:0] expRsp;
        logic            expErr;
        logic [31:0]     expRdata;
        bit              waiting;
        bit              toHit;
        int              win;
        if (!rst_n) begin
            checkOutput("rst_gnt",       32'(o_gnt),       32'h0);
            checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
            checkOutput("rst_rsp_err",   32'(o_rsp_err),   32'h0);
            checkOutput("rst_rsp_rdata", o_rsp_rdata,      32'h0);
            checkOutput("rst_mem_req",   32'(o_mem_req),   32'h0);
            checkOutput("rst_mem_we",    32'(o_mem_we),    32'h0);
            checkOutput("rst_mem_addr",  o_mem_addr,       32'h0);
            checkOutput("rst_mem_wdata", o_mem_wdata,      32'h0);
            checkOutput("rst_arb_busy",  32'(o_arb_busy),  32'h0);
            mActive   = 1'b0;
            mDraining = 1'b0;
            mAge      = 0;
            mOwner    = 0;
            mWe       = 1'b0;
            mAddr     = 32'h0;
            mWdata    = 32'h0;
            for (int i = 0; i < NREQ; i++) mStarve[i] = 0;
        end else begin
            waiting  = mActive && !mDraining && (mAge >= 2);
            toHit    = waiting && ((mAge - 1) == TIMEOUT);
            expGnt   = (mActive && mAge == 1) ? NREQ'(1) << mOwner : '0;
            expRsp   = (waiting && (i_mem_valid || toHit)) ? NREQ'(1) << mOwner : '0;
            expErr   = waiting && !i_mem_valid && toHit;
            expRdata = (waiting && i_mem_valid) ? i_mem_rdata : 32'h0;

            checkOutput("gnt",       32'(o_gnt),       32'(expGnt));
            checkOutput("mem_req",   32'(o_mem_req),   32'(mActive && mAge == 1));
            checkOutput("rsp_valid", 32'(o_rsp_valid), 32'(expRsp));
            checkOutput("rsp_err",   32'(o_rsp_err),   32'(expErr));
            checkOutput("rsp_rdata", o_rsp_rdata,      expRdata);
            checkOutput("mem_we",    32'(o_mem_we),    32'(mWe));
            checkOutput("mem_addr",  o_mem_addr,       mAddr);
            checkOutput("mem_wdata", o_mem_wdata,      mWdata);
            checkOutput("arb_busy",  32'(o_arb_busy),  32'(mActive));

            for (int i = 0; i < NREQ; i++) begin
                if (o_gnt[i]) begin
                    gntLog.push_back(i);
                    gntCycle[i] = cyc;
                    gntAddr[i]  = o_mem_addr;
                    gntWdata[i] = o_mem_wdata;
                    gntWe[i]    = o_mem_we;
                end
                if (o_rsp_valid[i]) begin
                    rspCycle[i] = cyc;
                    rspOwner    = i;
                    rspData     = o_rsp_rdata;
                    rspErr      = o_rsp_err;
                    rspCount++;
                end
            end

            // Advance the model to the state after the coming rising edge
            for (int i = 0; i < NREQ; i++) if (!i_req[i]) mStarve[i] = 0;
            if (!mActive) begin
                if ((|i_req) && !i_mem_busy) begin
                    win = -1;
                    for (int i = 0; i < NREQ; i++)
                        if (win < 0 && i_req[i] && mStarve[i] == STARVE_LIMIT) win = i;
                    for (int i = 0; i < NREQ; i++)
                        if (win < 0 && i_req[i]) win = i;
                    for (int i = 0; i < NREQ; i++) begin
                        if (i == win) mStarve[i] = 0;
                        else if (i_req[i] && mStarve[i] < STARVE_LIMIT) mStarve[i]++;
                    end
                    mActive = 1'b1;
                    mAge    = 1;
                    mOwner  = win;
                    mWe     = i_req_we[win];
                    mAddr   = i_req_addr[32*win +: 32];
                    mWdata  = i_req_wdata[32*win +: 32];
                end
            end else begin
                if (waiting && (|expRsp)) begin
                    if (expErr) mDraining = 1'b1;
                    else        mActive   = 1'b0;
                end else if (mDraining && i_mem_valid) begin
                    mDraining = 1'b0;
                    mActive   = 1'b0;
                end
                mAge++;
            end
        end
    end

    // Advance one cycle: inputs change 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        i_mem_valid = 1'b0;
        i_mem_rdata = $urandom;
        if (memCountdown > 0) begin
            memCountdown--;
            if (memCountdown == 0) begin
                i_mem_valid = 1'b1;
                if (memFixed) i_mem_rdata = memData;
            end
        end
        for (int i = 0; i < NREQ; i++)
            if (gntSeen[i] && !holdReq[i]) i_req[i] = 1'b0;
    endtask

    task automatic waitRsp(input int target, input int budget);
        int n = 0;
        while (rspCount < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput("wait_rsp_budget", 32'(rspCount >= target), 32'd1);
    endtask

    task automatic waitGnt(input int target, input int budget);
        int n = 0;
        while (gntLog.size() < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput("wait_gnt_budget", 32'(gntLog.size() >= target), 32'd1);
    endtask

    // Random requester, memory-busy and stray-response traffic for one cycle
    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (!i_req[i]) begin
                i_req_addr[32*i +: 32]  = $urandom;
                i_req_wdata[32*i +: 32] = $urandom;
                i_req_we[i]             = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) i_req[i] = 1'b1;
            end else if ($urandom_range(0, 29) == 0) begin
                i_req[i] = 1'b0;
            end
        end
        i_mem_busy = ($urandom_range(0, 3) == 0);
        if (memCountdown == 0 && $urandom_range(0, 24) == 0) i_mem_valid = 1'b1;
        memLatency = $urandom_range(1, 6);
        memSilent  = ($urandom_range(0, 39) == 0);
    endtask

    int t0;
    int g0;
    int rc;

    initial begin
        rst_n       = 1'b0;
        i_req       = '0;
        i_req_we    = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_mem_busy  = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_rdata = 32'h0;
        for (int i = 0; i < NREQ; i++) begin
            gntCycle[i] = 0;
            rspCycle[i] = 0;
            gntAddr[i]  = 32'h0;
            gntWdata[i] = 32'h0;
            gntWe[i]    = 1'b0;
        end

        tick();
        @(negedge clk);
        checkOutput("reset_arb_busy", 32'(o_arb_busy), 32'h0);
        checkOutput("reset_mem_addr", o_mem_addr, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single read: requester 1, address 0x40, latency 3
        $display("[TB] single read");
        memLatency = 3;
        memFixed   = 1'b1;
        memData    = 32'hDEADBEEF;
        i_req_addr[32 +: 32] = 32'h40;
        i_req_we[1] = 1'b0;
        i_req[1]    = 1'b1;
        t0 = cyc;
        waitRsp(rspCount + 1, 20);
        checkOutput("read_gnt_cycle",  32'(gntCycle[1] - t0), 32'd1);
        checkOutput("read_mem_addr",   gntAddr[1], 32'h40);
        checkOutput("read_rsp_cycle",  32'(rspCycle[1] - t0), 32'd4);
        checkOutput("read_rsp_owner",  32'(rspOwner), 32'd1);
        checkOutput("read_rsp_rdata",  rspData, 32'hDEADBEEF);
        checkOutput("read_rsp_err",    32'(rspErr), 32'd0);
        memFixed = 1'b0;
        tick();

        // Priority: requesters 0 and 2 raised together
        $display("[TB] priority");
        memLatency = 2;
        g0 = gntLog.size();
        i_req[0] = 1'b1;
        i_req[2] = 1'b1;
        waitRsp(rspCount + 2, 40);
        checkOutput("prio_first",  32'(gntLog[g0]), 32'd0);
        checkOutput("prio_second", 32'(gntLog[g0 + 1]), 32'd2);
        checkOutput("prio_gap",    32'(gntCycle[2] - rspCycle[0]), 32'd2);
        tick();

        // Starvation: requester 0 always requesting, requester 2 held high
        $display("[TB] starvation");
        i_req = '0;
        tick();
        tick();
        memLatency = 1;
        holdReq[0] = 1'b1;
        g0 = gntLog.size();
        i_req[0] = 1'b1;
        i_req[2] = 1'b1;
        waitGnt(g0 + 9, 300);
        for (int k = 0; k < 8; k++)
            checkOutput("starve_prio_win", 32'(gntLog[g0 + k]), 32'd0);
        checkOutput("starve_promoted", 32'(gntLog[g0 + 8]), 32'd2);
        holdReq[0] = 1'b0;
        i_req[0]   = 1'b0;
        repeat (20) tick();

        // Timeout: the memory never answers, a late mem_valid is drained
        $display("[TB] timeout");
        i_req = '0;
        memSilent = 1'b1;
        i_req_we[0] = 1'b0;
        i_req_addr[0 +: 32] = 32'h80;
        i_req[0] = 1'b1;
        t0 = cyc;
        waitRsp(rspCount + 1, 120);
        checkOutput("to_rsp_cycle", 32'(rspCycle[0] - t0), 32'd65);
        checkOutput("to_rsp_err",   32'(rspErr), 32'd1);
        checkOutput("to_rsp_rdata", rspData, 32'h0);
        while (cyc < t0 + 75) tick();
        i_mem_valid = 1'b1;
        rc = rspCount;
        @(negedge clk);
        checkOutput("drain_busy", 32'(o_arb_busy), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("drain_idle",    32'(o_arb_busy), 32'd0);
        checkOutput("drain_swallow", 32'(rspCount - rc), 32'd0);
        memSilent = 1'b0;
        tick();

        // Busy/write: no grant while mem_busy, grant one cycle after it drops
        $display("[TB] busy write");
        memLatency = 2;
        i_mem_busy = 1'b1;
        i_req_we[1] = 1'b1;
        i_req_addr[32 +: 32]  = 32'h100;
        i_req_wdata[32 +: 32] = 32'h12345678;
        i_req[1] = 1'b1;
        g0 = gntLog.size();
        repeat (5) tick();
        checkOutput("busy_no_gnt", 32'(gntLog.size() - g0), 32'd0);
        i_mem_busy = 1'b0;
        t0 = cyc;
        waitRsp(rspCount + 1, 20);
        checkOutput("write_gnt_cycle", 32'(gntCycle[1] - t0), 32'd1);
        checkOutput("write_mem_we",    32'(gntWe[1]), 32'd1);
        checkOutput("write_mem_addr",  gntAddr[1], 32'h100);
        checkOutput("write_mem_wdata", gntWdata[1], 32'h12345678);
        tick();

        // Reset while waiting for memory
        $display("[TB] reset in wait");
        memLatency = 20;
        g0 = gntLog.size();
        i_req_we[2] = 1'b0;
        i_req_addr[64 +: 32] = 32'h200;
        i_req[2] = 1'b1;
        waitGnt(g0 + 1, 10);
        repeat (4) tick();
        rc = rspCount;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstw_arb_busy",  32'(o_arb_busy), 32'd0);
        checkOutput("rstw_mem_addr",  o_mem_addr, 32'h0);
        checkOutput("rstw_rsp_valid", 32'(o_rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        checkOutput("rstw_no_rsp", 32'(rspCount - rc), 32'd0);
        memLatency = 3;
        i_req[0] = 1'b1;
        waitRsp(rspCount + 1, 20);
        checkOutput("rstw_fresh_owner", 32'(rspOwner), 32'd0);
        checkOutput("rstw_fresh_err",   32'(rspErr), 32'd0);

        // Randomized traffic
        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            tick();
            applyStimulus();
        end
        i_req      = '0;
        i_mem_busy = 1'b0;
        memSilent  = 1'b0;
        repeat (100) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
